// File: rtl/up_counter.sv
// Free-running up-counter wrapping at MAX_VAL, with terminal-count decode, wrap pulse and saturating wrap tally.
// Optional build macro UP_COUNTER_PRESCALE_EN inserts a PRESCALE-clock divider in front of every advance.
module up_counter #(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter int WRAPS_W  = 16,
    parameter int PRESCALE = 1
) (
    input  logic               clk,
    input  logic               reset,
    output logic [WIDTH-1:0]   counter,
    output logic               tc,
    output logic               wrap_pulse,
    output logic [WRAPS_W-1:0] wrap_count
);

    localparam logic [WIDTH-1:0]   LP_MAX      = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0]   LP_CNT_ONE  = WIDTH'(1);
    localparam logic [WRAPS_W-1:0] LP_WRAP_ONE = WRAPS_W'(1);

    if (MAX_VAL < 1 || (WIDTH < 31 && MAX_VAL >= (1 << WIDTH))) begin : g_bad_max_val
        $error("up_counter: MAX_VAL must lie in 1..2**WIDTH-1");
    end
    if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
        $error("up_counter: PRESCALE must lie in 1..65535");
    end

    logic               w_tick;
    logic               w_at_max;
    logic               w_wrap;
    logic [WIDTH-1:0]   r_counter;
    logic               r_wrap_pulse;
    logic [WRAPS_W-1:0] r_wrap_count;

`ifdef UP_COUNTER_PRESCALE_EN
    localparam logic [15:0] LP_PRE_LAST = 16'(PRESCALE - 1);

    logic [15:0] r_prescale;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prescale <= '0;
        end else if (w_tick) begin
            r_prescale <= '0;
        end else begin
            r_prescale <= r_prescale + 16'd1;
        end
    end

    assign w_tick = (r_prescale == LP_PRE_LAST);
`else
    assign w_tick = 1'b1;
`endif

    assign w_at_max = (r_counter == LP_MAX);
    assign w_wrap   = w_tick & w_at_max;

    // wrap_pulse is driven from w_wrap every clk edge, so it stays one clk wide even when prescaled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_counter    <= '0;
            r_wrap_pulse <= 1'b0;
            r_wrap_count <= '0;
        end else begin
            r_wrap_pulse <= w_wrap;
            if (w_tick) begin
                r_counter <= w_at_max ? '0 : r_counter + LP_CNT_ONE;
            end
            if (w_wrap && (r_wrap_count != '1)) begin
                r_wrap_count <= r_wrap_count + LP_WRAP_ONE;
            end
        end
    end

    assign counter    = r_counter;
    assign tc         = w_at_max;
    assign wrap_pulse = r_wrap_pulse;
    assign wrap_count = r_wrap_count;

endmodule

// File: tb/tb_up_counter.sv
// Directed bench for up_counter: power-up, rollover, custom MAX_VAL, async reset, saturation, long run.
// Prescaler scenario runs only when UP_COUNTER_PRESCALE_EN is defined.
module tb_up_counter;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    logic [7:0]  c0, c1, c2, c3;
    logic        tc0, tc1, tc2, tc3;
    logic        wp0, wp1, wp2, wp3;
    logic [15:0] wc0, wc1, wc3;
    logic [1:0]  wc2;

    up_counter u_dut0 (
        .clk(clk), .reset(reset), .counter(c0), .tc(tc0), .wrap_pulse(wp0), .wrap_count(wc0)
    );
    up_counter #(.MAX_VAL(9)) u_dut1 (
        .clk(clk), .reset(reset), .counter(c1), .tc(tc1), .wrap_pulse(wp1), .wrap_count(wc1)
    );
    up_counter #(.MAX_VAL(3), .WRAPS_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .counter(c2), .tc(tc2), .wrap_pulse(wp2), .wrap_count(wc2)
    );
    up_counter #(.PRESCALE(4)) u_dut3 (
        .clk(clk), .reset(reset), .counter(c3), .tc(tc3), .wrap_pulse(wp3), .wrap_count(wc3)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        checks++; if (c0 !== 8'd0) begin errors++; $display("FAIL reset_counter got=%0d exp=0", c0); end
        checks++; if (tc0 !== 1'b0) begin errors++; $display("FAIL reset_tc got=%b exp=0", tc0); end
        checks++; if (wp0 !== 1'b0) begin errors++; $display("FAIL reset_wrap_pulse got=%b exp=0", wp0); end
        checks++; if (wc0 !== 16'd0) begin errors++; $display("FAIL reset_wrap_count got=%0d exp=0", wc0); end
        checks++; if (c1 !== 8'd0) begin errors++; $display("FAIL reset_counter_m9 got=%0d exp=0", c1); end
        #17;
        checks++; if (c0 !== 8'd0) begin errors++; $display("FAIL reset_hold got=%0d exp=0", c0); end
        reset = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            checks++;
            if (c0 !== 8'(i)) begin
                errors++; $display("FAIL powerup_count edge=%0d got=%0d exp=%0d", i, c0, i);
            end
        end
    endtask

    task automatic test_rollover();
        logic [7:0] exp;
        apply_reset();
        checks++; if (c0 !== 8'd0) begin errors++; $display("FAIL roll_start got=%0d exp=0", c0); end
        for (int i = 1; i <= 257; i++) begin
            step();
            exp = 8'(i % 256);
            checks++;
            if (c0 !== exp || tc0 !== (exp == 8'd255) || wp0 !== (i == 256) || wc0 !== ((i >= 256) ? 16'd1 : 16'd0)) begin
                errors++;
                $display("FAIL rollover edge=%0d got c=%0d tc=%b wp=%b wc=%0d exp c=%0d tc=%b wp=%b wc=%0d",
                         i, c0, tc0, wp0, wc0, exp, (exp == 8'd255), (i == 256), (i >= 256) ? 1 : 0);
            end
        end
    endtask

    task automatic test_custom_max();
        logic [7:0] exp;
        apply_reset();
        for (int i = 1; i <= 35; i++) begin
            step();
            exp = 8'(i % 10);
            checks++;
            if (c1 !== exp || tc1 !== (exp == 8'd9) || wp1 !== (exp == 8'd0) || wc1 !== 16'(i / 10)) begin
                errors++;
                $display("FAIL custom_max edge=%0d got c=%0d tc=%b wp=%b wc=%0d exp c=%0d tc=%b wp=%b wc=%0d",
                         i, c1, tc1, wp1, wc1, exp, (exp == 8'd9), (exp == 8'd0), i / 10);
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 384; i++) step();
        checks++; if (c0 !== 8'h80) begin errors++; $display("FAIL midcount_pre got=%0d exp=128", c0); end
        checks++; if (wc0 !== 16'd1) begin errors++; $display("FAIL midcount_wc_pre got=%0d exp=1", wc0); end
        #2 reset = 1'b1;
        #1;
        checks++; if (c0 !== 8'd0) begin errors++; $display("FAIL async_counter got=%0d exp=0", c0); end
        checks++; if (wp0 !== 1'b0) begin errors++; $display("FAIL async_wrap_pulse got=%b exp=0", wp0); end
        checks++; if (wc0 !== 16'd0) begin errors++; $display("FAIL async_wrap_count got=%0d exp=0", wc0); end
        checks++; if (tc0 !== 1'b0) begin errors++; $display("FAIL async_tc got=%b exp=0", tc0); end
        @(negedge clk);
        reset = 1'b0;
        step();
        checks++; if (c0 !== 8'd1) begin errors++; $display("FAIL async_resume got=%0d exp=1", c0); end
    endtask

    task automatic test_saturate();
        apply_reset();
        for (int i = 1; i <= 24; i++) begin
            step();
            if (i % 4 == 0) begin
                checks++;
                if (wc2 !== 2'((i / 4 > 3) ? 3 : i / 4) || wp2 !== 1'b1 || c2 !== 8'd0) begin
                    errors++;
                    $display("FAIL saturate edge=%0d got wc=%0d wp=%b c=%0d exp wc=%0d wp=1 c=0",
                             i, wc2, wp2, c2, (i / 4 > 3) ? 3 : i / 4);
                end
            end
        end
    endtask

    task automatic test_long_run();
        logic [7:0] m_cnt;
        logic       m_wp;
        int         m_wc;
        apply_reset();
        m_cnt = 8'd0;
        m_wc  = 0;
        for (int i = 1; i <= 3000; i++) begin
            step();
            m_wp  = (m_cnt == 8'd255);
            m_cnt = m_cnt + 8'd1;
            if (m_wp) m_wc++;
            checks++;
            if ($isunknown({c0, tc0, wp0, wc0}) || c0 !== m_cnt || tc0 !== (m_cnt == 8'd255) ||
                wp0 !== m_wp || wc0 !== 16'(m_wc)) begin
                errors++;
                $display("FAIL long_run edge=%0d got c=%0d tc=%b wp=%b wc=%0d exp c=%0d wp=%b wc=%0d",
                         i, c0, tc0, wp0, wc0, m_cnt, m_wp, m_wc);
            end
        end
        checks++; if (c0 !== 8'd184) begin errors++; $display("FAIL long_final_counter got=%0d exp=184", c0); end
        checks++; if (wc0 !== 16'd11) begin errors++; $display("FAIL long_final_wraps got=%0d exp=11", wc0); end
    endtask

`ifdef UP_COUNTER_PRESCALE_EN
    task automatic test_prescale();
        logic [7:0] exp;
        apply_reset();
        for (int i = 1; i <= 1030; i++) begin
            step();
            exp = 8'((i / 4) % 256);
            checks++;
            if (c3 !== exp || wp3 !== (i == 1024) || wc3 !== ((i >= 1024) ? 16'd1 : 16'd0)) begin
                errors++;
                $display("FAIL prescale edge=%0d got c=%0d wp=%b wc=%0d exp c=%0d wp=%b wc=%0d",
                         i, c3, wp3, wc3, exp, (i == 1024), (i >= 1024) ? 1 : 0);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_rollover();
        test_custom_max();
        test_async_reset();
        test_saturate();
        test_long_run();
`ifdef UP_COUNTER_PRESCALE_EN
        test_prescale();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
